// File: rtl/gb_regfile.sv
// gb_regfile: general-purpose register file of NUM_REGS byte registers
// organised as 16-bit pairs (default B,C,D,E,H,L,A,F), with an
// increment/decrement unit (IDU) working on whole pairs.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   wr_*                byte write port (enable, index, data)
//   pair_wr_*           pair write port; high byte -> reg 2p, low -> reg 2p+1
//   idu_en_i/dec_i/sel_i  IDU enable, direction (1 = -1), pair index
//   rd_sel_a/b_i, rd_data_a/b_o   two byte read ports
//   pair_rd_sel_i, pair_rd_data_o pair read port, {reg 2p, reg 2p+1}
//   idu_carry_o         registered; 1 when the last IDU operation wrapped
//
// Simultaneous updates are resolved per byte: pair write > IDU > byte write.
// Reads are combinational; with BYPASS = 1 they forward the same-cycle
// winning pair/byte write data, but never the IDU result.
module gb_regfile #(
  parameter int                DATA_W    = 8,
  parameter int                NUM_REGS  = 8,
  parameter int                FLAG_IDX  = 7,
  parameter logic [DATA_W-1:0] FLAG_MASK = 8'hF0,
  parameter int                BYPASS    = 1,
  localparam int               NUM_PAIRS = NUM_REGS / 2,
  localparam int               SEL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int               PSEL_W    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [SEL_W-1:0]    wr_sel_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                pair_wr_en_i,
  input  logic [PSEL_W-1:0]   pair_wr_sel_i,
  input  logic [2*DATA_W-1:0] pair_wr_data_i,
  input  logic                idu_en_i,
  input  logic                idu_dec_i,
  input  logic [PSEL_W-1:0]   idu_sel_i,
  input  logic [SEL_W-1:0]    rd_sel_a_i,
  input  logic [SEL_W-1:0]    rd_sel_b_i,
  output logic [DATA_W-1:0]   rd_data_a_o,
  output logic [DATA_W-1:0]   rd_data_b_o,
  input  logic [PSEL_W-1:0]   pair_rd_sel_i,
  output logic [2*DATA_W-1:0] pair_rd_data_o,
  output logic                idu_carry_o
);

  localparam logic [2*DATA_W-1:0] PAIR_ONE = {{(2*DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]   regs_q  [NUM_REGS];
  logic [DATA_W-1:0]   nxt_val [NUM_REGS];
  logic                upd     [NUM_REGS];
  logic [DATA_W-1:0]   rd_view [NUM_REGS];

  logic [2*DATA_W-1:0] idu_cur;
  logic [2*DATA_W-1:0] idu_res;
  logic                idu_hit_any;
  logic                idu_wrap;

  // The flag register only ever holds its writable bits.
  function automatic logic [DATA_W-1:0] mask_byte(input int idx,
                                                  input logic [DATA_W-1:0] v);
    return (idx == FLAG_IDX) ? (v & FLAG_MASK) : v;
  endfunction

  // IDU operates on the stored pair only; an out-of-range index is a no-op.
  always_comb begin
    idu_cur     = '0;
    idu_hit_any = 1'b0;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (idu_en_i && (idu_sel_i == PSEL_W'(p))) begin
        idu_cur     = {regs_q[2*p], regs_q[2*p+1]};
        idu_hit_any = 1'b1;
      end
    end
    idu_res  = idu_dec_i ? (idu_cur - PAIR_ONE) : (idu_cur + PAIR_ONE);
    idu_wrap = idu_dec_i ? (idu_cur == '0) : (idu_cur == '1);
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_byte
    localparam int P = i / 2;
    logic              pw_hit;
    logic              idu_hit;
    logic              bw_hit;
    logic              byp_hit;
    logic [DATA_W-1:0] pw_byte;
    logic [DATA_W-1:0] idu_byte;
    logic [DATA_W-1:0] byp_val;

    if (i % 2 == 0) begin : g_hi
      assign pw_byte  = pair_wr_data_i[2*DATA_W-1:DATA_W];
      assign idu_byte = idu_res[2*DATA_W-1:DATA_W];
    end else begin : g_lo
      assign pw_byte  = pair_wr_data_i[DATA_W-1:0];
      assign idu_byte = idu_res[DATA_W-1:0];
    end

    assign pw_hit  = pair_wr_en_i && (pair_wr_sel_i == PSEL_W'(P));
    assign idu_hit = idu_en_i && (idu_sel_i == PSEL_W'(P));
    assign bw_hit  = wr_en_i && (wr_sel_i == SEL_W'(i));

    assign upd[i]     = pw_hit || idu_hit || bw_hit;
    assign nxt_val[i] = mask_byte(i, pw_hit ? pw_byte : (idu_hit ? idu_byte : wr_data_i));

    // A byte claimed by the IDU shows its stored value, since the IDU
    // result itself is not forwarded.
    assign byp_hit    = pw_hit || (bw_hit && !idu_hit);
    assign byp_val    = mask_byte(i, pw_hit ? pw_byte : wr_data_i);
    assign rd_view[i] = ((BYPASS != 0) && byp_hit) ? byp_val : regs_q[i];
  end

  // Unmatched (out-of-range) indices leave the read data at 0.
  always_comb begin
    rd_data_a_o    = '0;
    rd_data_b_o    = '0;
    pair_rd_data_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel_a_i == SEL_W'(i)) rd_data_a_o = rd_view[i];
      if (rd_sel_b_i == SEL_W'(i)) rd_data_b_o = rd_view[i];
    end
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (pair_rd_sel_i == PSEL_W'(p)) pair_rd_data_o = {rd_view[2*p], rd_view[2*p+1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      idu_carry_o <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (upd[i]) regs_q[i] <= nxt_val[i];
      end
      // Carry follows the IDU even when a pair write overrides its result.
      if (idu_hit_any) idu_carry_o <= idu_wrap;
    end
  end

endmodule
